// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the system bus: master count, owner index type,
// arbiter state encoding and the active-low request/grant levels.
// Optional feature macro used by the arbiter: BUS_ARB_PARK_EN.
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam int BUS_MASTER_CNT = 4;
    localparam int BUS_IDX_W      = $clog2(BUS_MASTER_CNT);

    // Bus handshake levels: requests and grants are active-low.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef logic [BUS_IDX_W-1:0] bus_master_idx_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } bus_arb_state_t;

endpackage : bus_pkg

// File: rtl/bus_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// bus_arb_rr_pick
// Combinational round-robin pick. Searches base+1, base+2, ..., base+MASTER_CNT
// (modulo MASTER_CNT) for the first master with req_ low, so the base master is
// considered last.
// Ports:
//   req_    - per-master request, active-low
//   base    - rotation base (current owner)
//   pick    - index of the first requesting master in rotation order
//   any_req - high when at least one req_ is low
// -----------------------------------------------------------------------------
module bus_arb_rr_pick
    import bus_pkg::*;
#(
    parameter int MASTER_CNT = BUS_MASTER_CNT,
    parameter int IDX_W      = $clog2(MASTER_CNT)
) (
    input  logic [MASTER_CNT-1:0] req_,
    input  logic [IDX_W-1:0]      base,
    output logic [IDX_W-1:0]      pick,
    output logic                  any_req
);

    logic [MASTER_CNT-1:0] rot;     // active-high requests, bit k = master base+1+k
    int                    k_sel;
    logic                  found;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the loops leaves a value held, which would infer a latch.
        rot     = '0;
        k_sel   = 0;
        found   = 1'b0;
        pick    = '0;
        any_req = 1'b0;

        // Rotate so that position 0 is the master just after the base.
        for (int k = 0; k < MASTER_CNT; k++) begin
            int j;
            j = (int'(base) + 1 + k) % MASTER_CNT;
            rot[k] = (req_[j[IDX_W-1:0]] == ENABLE_);
        end

        // Priority-encode: lowest rotated position wins.
        for (int k = 0; k < MASTER_CNT; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                k_sel = k;
            end
        end

        // Un-rotate back to a master index.
        pick    = IDX_W'((int'(base) + 1 + k_sel) % MASTER_CNT);
        any_req = found;
    end

endmodule : bus_arb_rr_pick

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for the shared system bus using the active-low req_/grnt_
// handshake. The owner keeps the bus until it drops req_; the next owner is the
// first requester after it in rotation order. grnt_ and owner_vld are decoded
// from registers only, so there is no combinational req_ -> grnt_ path.
//
// Configuration macro: BUS_ARB_PARK_EN
//   defined   - grant stays parked on the last owner when nobody requests;
//               reset parks the grant on master 0.
//   undefined - arbiter returns to ARB_IDLE with no grant when nobody requests.
//
// Ports:
//   clk       - system clock, rising edge
//   rst       - asynchronous reset, active-high
//   req_      - per-master bus request, active-low
//   grnt_     - per-master grant, active-low, at most one bit low
//   owner     - index of the current owner (master mux select)
//   owner_vld - high while any grant is asserted
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int MASTER_CNT = BUS_MASTER_CNT,
    parameter int IDX_W      = $clog2(MASTER_CNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MASTER_CNT-1:0] req_,
    output logic [MASTER_CNT-1:0] grnt_,
    output logic [IDX_W-1:0]      owner,
    output logic                  owner_vld
);

`ifdef BUS_ARB_PARK_EN
    localparam bus_arb_state_t RST_STATE = ARB_OWN;
`else
    localparam bus_arb_state_t RST_STATE = ARB_IDLE;
`endif

    bus_arb_state_t   state;
    logic [IDX_W-1:0] pick;
    logic             any_req;

    bus_arb_rr_pick #(
        .MASTER_CNT (MASTER_CNT),
        .IDX_W      (IDX_W)
    ) u_pick (
        .req_    (req_),
        .base    (owner),
        .pick    (pick),
        .any_req (any_req)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
            owner <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        owner <= pick;
                        state <= ARB_OWN;
                    end
                end
                ARB_OWN: begin
                    if (req_[owner] == ENABLE_) begin
                        // Owner keeps the bus; no preemption.
                        owner <= owner;
                    end else if (any_req) begin
                        // Owner is not requesting, so the pick is someone else.
                        owner <= pick;
                    end else begin
`ifdef BUS_ARB_PARK_EN
                        owner <= owner;
`else
                        // Owner is kept as the rotation base for the next pick.
                        state <= ARB_IDLE;
`endif
                    end
                end
                default: begin
                    state <= RST_STATE;
                    owner <= '0;
                end
            endcase
        end
    end

    always_comb begin
        grnt_ = {MASTER_CNT{DISABLE_}};
        if (state == ARB_OWN) begin
            grnt_[owner] = ENABLE_;
        end
    end

    assign owner_vld = (state == ARB_OWN);

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter (4 masters). A vector table covers hold,
// handover, wrap-around and release behaviour; hand-written sequences cover
// idle grant latency, drop-and-re-request rotation and asynchronous reset.
// Expected values follow BUS_ARB_PARK_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int N = 4;

`ifdef BUS_ARB_PARK_EN
    localparam logic [3:0] RST_GRNT = 4'b1110;
    localparam logic       RST_VLD  = 1'b1;
    localparam bit         PARKED   = 1'b1;
`else
    localparam logic [3:0] RST_GRNT = 4'b1111;
    localparam logic       RST_VLD  = 1'b0;
    localparam bit         PARKED   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_ = 4'b1111;
    logic [3:0] grnt_;
    logic [1:0] owner;
    logic       owner_vld;

    int checks   = 0;
    int failures = 0;

    bus_arbiter #(.MASTER_CNT(N), .IDX_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_      (req_),
        .grnt_     (grnt_),
        .owner     (owner),
        .owner_vld (owner_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grnt;
        logic [1:0] owner;
        logic       vld;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [3:0] g, input logic [1:0] o, input logic v);
        check({name, " grnt_"},     32'(grnt_),     32'(g));
        check({name, " owner"},     32'(owner),     32'(o));
        check({name, " owner_vld"}, 32'(owner_vld), 32'(v));
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Owner 0 first; then 10 cycles of hold with master 3 also requesting.
        vecs.push_back('{4'b1110, 4'b1110, 2'd0, 1'b1});
        for (int i = 0; i < 10; i++) vecs.push_back('{4'b0110, 4'b1110, 2'd0, 1'b1});
        // Master 0 releases: handover to 3.
        vecs.push_back('{4'b0111, 4'b0111, 2'd3, 1'b1});
        // Master 3 releases while 0,1,2 request: wrap to 0, then 1, then 2.
        vecs.push_back('{4'b1000, 4'b1110, 2'd0, 1'b1});
        vecs.push_back('{4'b1001, 4'b1101, 2'd1, 1'b1});
        vecs.push_back('{4'b1011, 4'b1011, 2'd2, 1'b1});
        // Nobody requests: park on 2 or go idle keeping owner 2 as base.
        if (PARKED) begin
            vecs.push_back('{4'b1111, 4'b1011, 2'd2, 1'b1});
            vecs.push_back('{4'b1111, 4'b1011, 2'd2, 1'b1});
        end else begin
            vecs.push_back('{4'b1111, 4'b1111, 2'd2, 1'b0});
            vecs.push_back('{4'b1111, 4'b1111, 2'd2, 1'b0});
        end

        // Reset state (asynchronous, checked before any edge).
        #2;
        check_out("reset", RST_GRNT, 2'd0, RST_VLD);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            req_ = vecs[i].req;
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].grnt, vecs[i].owner, vecs[i].vld);
        end

        // Grant latency from idle: req_[2] applied after an edge, no grant
        // before the next edge (parked owner 2 already holds it).
        req_ = 4'b1011;
        #2;
        check("latency pre-edge grnt_", 32'(grnt_), PARKED ? 32'h0000000B : 32'h0000000F);
        tick();
        check_out("latency post-edge", 4'b1011, 2'd2, 1'b1);
        req_ = 4'b1111;
        tick();

        // Master 1 gets the bus, drops req_ for one cycle while 2 requests.
        req_ = 4'b1101;
        tick();
        check_out("m1 own", 4'b1101, 2'd1, 1'b1);
        req_ = 4'b1001;
        tick();
        check_out("m1 hold", 4'b1101, 2'd1, 1'b1);
        req_ = 4'b1011;
        tick();
        check_out("m1 drop", 4'b1011, 2'd2, 1'b1);
        req_ = 4'b1001;
        tick();
        check_out("m1 rereq", 4'b1011, 2'd2, 1'b1);
        req_ = 4'b1101;
        tick();
        check_out("m2 release", 4'b1101, 2'd1, 1'b1);

        // Move to owner 2, then reset mid-tenure between edges.
        req_ = 4'b1011;
        tick();
        check_out("pre-rst", 4'b1011, 2'd2, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_out("async rst", RST_GRNT, 2'd0, RST_VLD);
        tick();
        check_out("rst held", RST_GRNT, 2'd0, RST_VLD);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_out("post-rst arb", 4'b1011, 2'd2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bus_arbiter
